sw_cmd_sched: RTL and testbench

//  Command scheduler in front of stopwatch_top. Arbitrates start/stop/clear/lap commands from two requesters
//  (0 = local button panel, 1 = host) and issues legal 1-cycle start/stop/reset pulses to the stopwatch.

---
 rtl/sw_pkg.sv | 19 +
 rtl/sw_lap_fifo.sv | 60 ++++++
 rtl/sw_cmd_sched.sv | 145 ++++++++++++++
 tb/tb_sw_cmd_sched.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared command and state encodings for the stopwatch command scheduler
// and the stopwatch top level.
package sw_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_STOP  = 2'b01,
        CMD_CLEAR = 2'b10,
        CMD_LAP   = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_CLR   = 2'b11
    } state_e;

endpackage

// File: rtl/sw_lap_fifo.sv
// First-word-fall-through lap buffer: DEPTH entries of W bits with push, pop
// and flush. The head word reads as zero while the buffer is empty.
module sw_lap_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == C_FULL);
    // A pop in the same cycle never makes room for a push into a full buffer.
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    // NOTE: storage has no reset; validity is tracked by r_count alone, which keeps it plain RAM.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: state is updated with <= so every register sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sw_cmd_sched.sv
// Round-robin command scheduler for the stopwatch: grants one requester per
// cycle, issues registered start/stop/reset pulses and records lap times.
module sw_cmd_sched #(
    parameter int LAP_DEPTH = 4,
    parameter int MIN_W     = 8,
    parameter int SEC_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [1:0]       req_cmd0,
    input  logic [1:0]       req_cmd1,
    output logic [1:0]       req_ready,
    output logic             sw_start,
    output logic             sw_stop,
    output logic             sw_reset,
    input  logic [MIN_W-1:0] sw_mins,
    input  logic [SEC_W-1:0] sw_secs,
    output logic [1:0]       state,
    output logic             cmd_err,
    output logic             lap_empty,
    output logic [MIN_W-1:0] lap_mins,
    output logic [SEC_W-1:0] lap_secs,
    input  logic             lap_rd,
    output logic             lap_ovf
);
    import sw_pkg::*;

    localparam int LW = MIN_W + SEC_W;

    state_e        r_state;
    logic          r_start, r_stop, r_reset, r_err;
    logic          r_last;
    logic          r_ovf;

    state_e        w_nxt;
    logic          w_start, w_stop, w_reset, w_err;
    logic          w_push, w_flush;
    logic [1:0]    w_gnt;
    logic          w_any, w_open, w_accept, w_sel;
    cmd_e          w_cmd;
    logic [LW-1:0] w_head;
    logic          w_full;

    // Arbiter: contention goes to the requester not served last.
    always_comb begin
        w_any    = |req_valid;
        w_open   = !rst && (r_state != ST_CLR);
        w_gnt    = (&req_valid) ? (r_last ? 2'b01 : 2'b10) : req_valid;
        w_accept = w_open && w_any;
        w_sel    = w_gnt[1];
        w_cmd    = w_sel ? cmd_e'(req_cmd1) : cmd_e'(req_cmd0);
    end

    assign req_ready = !w_open ? 2'b00 : (w_any ? w_gnt : 2'b11);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_nxt   = r_state;
        w_start = 1'b0;
        w_stop  = 1'b0;
        w_reset = 1'b0;
        w_err   = 1'b0;
        w_push  = 1'b0;
        w_flush = 1'b0;
        case (r_state)
            ST_IDLE: if (w_accept) begin
                case (w_cmd)
                    CMD_START: begin w_start = 1'b1; w_nxt = ST_RUN; end
                    CMD_CLEAR: begin w_reset = 1'b1; w_flush = 1'b1; w_nxt = ST_CLR; end
                    default:   w_err = 1'b1;
                endcase
            end
            ST_RUN: if (w_accept) begin
                case (w_cmd)
                    CMD_STOP:  begin w_stop = 1'b1; w_nxt = ST_PAUSE; end
                    CMD_LAP:   w_push = 1'b1;
                    CMD_CLEAR: begin
                        w_stop  = 1'b1;
                        w_reset = 1'b1;
                        w_flush = 1'b1;
                        w_nxt   = ST_CLR;
                    end
                    default:   w_err = 1'b1;
                endcase
            end
            ST_PAUSE: if (w_accept) begin
                case (w_cmd)
                    CMD_START: begin w_start = 1'b1; w_nxt = ST_RUN; end
                    CMD_LAP:   w_push = 1'b1;
                    CMD_CLEAR: begin w_reset = 1'b1; w_flush = 1'b1; w_nxt = ST_CLR; end
                    default:   w_err = 1'b1;
                endcase
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_reset <= 1'b0;
            r_err   <= 1'b0;
            r_last  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_start <= w_start;
            r_stop  <= w_stop;
            r_reset <= w_reset;
            r_err   <= w_err;
            if (w_accept) r_last <= w_sel;
            if (w_flush)                r_ovf <= 1'b0;
            else if (w_push && w_full)  r_ovf <= 1'b1;
        end
    end

    sw_lap_fifo #(
        .DEPTH (LAP_DEPTH),
        .W     (LW)
    ) u_lap_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  ({sw_mins, sw_secs}),
        .i_pop   (lap_rd),
        .o_data  (w_head),
        .o_empty (lap_empty),
        .o_full  (w_full)
    );

    // Reset in the cycle after acceptance cancels a pulse that is already registered.
    assign sw_start = r_start && !rst;
    assign sw_stop  = r_stop  && !rst;
    assign sw_reset = r_reset && !rst;
    assign cmd_err  = r_err   && !rst;
    assign state    = r_state;
    assign lap_ovf  = r_ovf;
    assign lap_mins = w_head[LW-1:SEC_W];
    assign lap_secs = w_head[SEC_W-1:0];

endmodule

// File: tb/tb_sw_cmd_sched.sv
// Directed bench for sw_cmd_sched: arbitration, FSM pulses, lap buffer and resets.
module tb_sw_cmd_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_cmd0, req_cmd1;
    logic [1:0] req_ready;
    logic       sw_start, sw_stop, sw_reset;
    logic [7:0] sw_mins;
    logic [5:0] sw_secs;
    logic [1:0] state;
    logic       cmd_err, lap_empty, lap_rd, lap_ovf;
    logic [7:0] lap_mins;
    logic [5:0] lap_secs;

    int errors = 0;
    int checks = 0;

    sw_cmd_sched #(.LAP_DEPTH(4), .MIN_W(8), .SEC_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_cmd0  (req_cmd0),
        .req_cmd1  (req_cmd1),
        .req_ready (req_ready),
        .sw_start  (sw_start),
        .sw_stop   (sw_stop),
        .sw_reset  (sw_reset),
        .sw_mins   (sw_mins),
        .sw_secs   (sw_secs),
        .state     (state),
        .cmd_err   (cmd_err),
        .lap_empty (lap_empty),
        .lap_mins  (lap_mins),
        .lap_secs  (lap_secs),
        .lap_rd    (lap_rd),
        .lap_ovf   (lap_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input string tag, input logic [2:0] exp);
        check(tag, {29'd0, sw_start, sw_stop, sw_reset}, {29'd0, exp});
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_cmd0 = 2'b00; req_cmd1 = 2'b00;
        sw_mins = 8'd0; sw_secs = 6'd0; lap_rd = 1'b0;
        tick(); tick();
        check("rst_ready", req_ready, 2'b00);
        check("rst_state", state, 2'b00);
        check("rst_empty", lap_empty, 1'b1);
        check("rst_ovf", lap_ovf, 1'b0);
        check("rst_lapdata", {lap_mins, lap_secs}, 14'd0);
        pulses("rst_pulses", 3'b000);
        check("rst_err", cmd_err, 1'b0);

        // 1: release reset, req0 START
        rst = 1'b0; #1;
        check("ready_after_rst", req_ready, 2'b11);
        req_valid = 2'b01; req_cmd0 = 2'b00; #1;
        check("t1_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        pulses("t1_start_pulse", 3'b100);
        check("t1_state", state, 2'b01);
        tick();
        pulses("t1_pulse_end", 3'b000);
        check("t1_state_hold", state, 2'b01);

        // 2: contention, req1 LAP wins first, then req0 STOP
        sw_mins = 8'd2; sw_secs = 6'd10;
        req_valid = 2'b11; req_cmd0 = 2'b01; req_cmd1 = 2'b11; #1;
        check("t2_ready_r1", req_ready, 2'b10);
        tick();
        check("t2_lap_empty", lap_empty, 1'b0);
        check("t2_lap_data", {lap_mins, lap_secs}, {8'd2, 6'd10});
        check("t2_state_run", state, 2'b01);
        pulses("t2_no_pulse", 3'b000);
        check("t2_ready_r0", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        pulses("t2_stop_pulse", 3'b010);
        check("t2_state_pause", state, 2'b10);
        check("t2_one_lap_only", lap_secs, 6'd10);
        lap_rd = 1'b1; tick(); lap_rd = 1'b0;
        check("t2_popped", lap_empty, 1'b1);

        // clear from PAUSED back to IDLE
        req_valid = 2'b01; req_cmd0 = 2'b10; tick(); req_valid = 2'b00;
        pulses("pclr_pulses", 3'b001);
        check("pclr_state", state, 2'b11);
        check("pclr_ready", req_ready, 2'b00);
        tick();
        check("pclr_idle", state, 2'b00);
        check("pclr_ready_back", req_ready, 2'b11);

        // 3: illegal STOP in IDLE
        req_valid = 2'b10; req_cmd1 = 2'b01; tick(); req_valid = 2'b00;
        check("t3_err", cmd_err, 1'b1);
        pulses("t3_no_pulse", 3'b000);
        check("t3_state", state, 2'b00);
        tick();
        check("t3_err_end", cmd_err, 1'b0);

        // 4: five laps into a four-entry buffer
        req_valid = 2'b10; req_cmd1 = 2'b00; tick(); req_valid = 2'b00;
        check("t4_run", state, 2'b01);
        req_cmd0 = 2'b11;
        for (int s = 3; s <= 7; s++) begin
            sw_secs = 6'(s); req_valid = 2'b01; tick();
            check("t4_ovf_step", lap_ovf, (s == 7) ? 1'b1 : 1'b0);
        end
        req_valid = 2'b00;
        for (int s = 3; s <= 6; s++) begin
            check("t4_pop_secs", lap_secs, 6'(s));
            check("t4_pop_nonempty", lap_empty, 1'b0);
            lap_rd = 1'b1; tick();
        end
        lap_rd = 1'b0;
        check("t4_empty", lap_empty, 1'b1);
        check("t4_empty_data", lap_secs, 6'd0);
        check("t4_ovf_sticky", lap_ovf, 1'b1);
        lap_rd = 1'b1; tick(); lap_rd = 1'b0;
        check("t4_pop_empty_ignored", lap_empty, 1'b1);

        // full + push + pop drops the push; non-full push + pop keeps occupancy
        for (int s = 20; s <= 23; s++) begin
            sw_secs = 6'(s); req_valid = 2'b01; tick();
        end
        sw_secs = 6'd24; lap_rd = 1'b1; tick();
        check("full_pushpop_head", lap_secs, 6'd21);
        sw_secs = 6'd25; tick();
        req_valid = 2'b00;
        check("pushpop_head", lap_secs, 6'd22);
        tick(); lap_rd = 1'b0;
        check("two_left_head", lap_secs, 6'd23);
        check("two_left_nonempty", lap_empty, 1'b0);

        // 5: CLEAR while RUNNING with laps stored
        req_valid = 2'b01; req_cmd0 = 2'b10; #1;
        check("t5_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        pulses("t5_stop_reset", 3'b011);
        check("t5_state_clr", state, 2'b11);
        check("t5_ready_clr", req_ready, 2'b00);
        check("t5_flushed", lap_empty, 1'b1);
        check("t5_ovf_clr", lap_ovf, 1'b0);
        tick();
        check("t5_idle", state, 2'b00);
        pulses("t5_pulse_end", 3'b000);

        // 6: reset the cycle after a START is accepted
        req_valid = 2'b01; req_cmd0 = 2'b00; tick();
        rst = 1'b1; req_valid = 2'b00; #1;
        check("t6_start_suppressed", sw_start, 1'b0);
        check("t6_ready_rst", req_ready, 2'b00);
        tick();
        check("t6_state", state, 2'b00);
        check("t6_empty", lap_empty, 1'b1);
        rst = 1'b0; tick();
        pulses("t6_no_pulse", 3'b000);
        check("t6_ready_back", req_ready, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
